// File: rtl/core_csr_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_csr_if : CSR access bus between the pipeline (master) and core_csr
// (slave). Carries the combinational read port, its illegal-access flag and
// the write port.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface core_csr_if;
  logic [11:0] i_csr_raddr;
  logic [31:0] o_csr_rdata;
  logic        o_csr_illegal;
  logic        i_csr_wen;
  logic [11:0] i_csr_waddr;
  logic [31:0] i_csr_wdata;

  modport master (
    output i_csr_raddr, i_csr_wen, i_csr_waddr, i_csr_wdata,
    input  o_csr_rdata, o_csr_illegal
  );

  modport slave (
    input  i_csr_raddr, i_csr_wen, i_csr_waddr, i_csr_wdata,
    output o_csr_rdata, o_csr_illegal
  );
endinterface
`default_nettype wire

// File: rtl/core_csr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_csr : machine-mode CSR file (mstatus/mie/mtvec/mscratch/mepc/mcause/
// mip, 64-bit mcycle/minstret, mhartid) with trap/mret sequencing and
// interrupt pending/cause generation.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module core_csr #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  wire logic            i_clk,
  input  wire logic            i_rst,
  core_csr_if.slave            bus,
  input  wire logic            i_retire,
  input  wire logic            i_trap,
  input  wire logic [31:0]     i_trap_cause,
  input  wire logic [31:0]     i_trap_epc,
  input  wire logic            i_mret,
  input  wire logic            i_irq_ext,
  input  wire logic            i_irq_timer,
  output logic                 o_irq_pending,
  output logic [31:0]          o_irq_cause,
  output logic [XLEN-1:0]      o_mtvec,
  output logic [XLEN-1:0]      o_mepc
);

  localparam logic [11:0] c_MSTATUS  = 12'h300;
  localparam logic [11:0] c_MIE      = 12'h304;
  localparam logic [11:0] c_MTVEC    = 12'h305;
  localparam logic [11:0] c_MSCRATCH = 12'h340;
  localparam logic [11:0] c_MEPC     = 12'h341;
  localparam logic [11:0] c_MCAUSE   = 12'h342;
  localparam logic [11:0] c_MIP      = 12'h344;
  localparam logic [11:0] c_MCYCLE   = 12'hB00;
  localparam logic [11:0] c_MINSTRET = 12'hB02;
  localparam logic [11:0] c_MCYCLEH  = 12'hB80;
  localparam logic [11:0] c_MINSTRETH= 12'hB82;
  localparam logic [11:0] c_MHARTID  = 12'hF14;
  localparam logic [31:0] c_CAUSE_EXT = 32'h8000_000B;
  localparam logic [31:0] c_CAUSE_TIM = 32'h8000_0007;

  logic            r_mstatus_mie, r_mstatus_mpie;
  logic            r_mie_meie, r_mie_mtie;
  logic            r_mip_meip, r_mip_mtip;
  logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
  logic [63:0]     r_mcycle, r_minstret;

  logic [31:0] w_mstatus, w_mie, w_mip, w_rdata;
  logic        w_rd_valid, w_wr_valid;
  logic [63:0] w_mcycle_nxt, w_minstret_nxt, w_mcycle_inc, w_minstret_inc;
  logic        w_we_mstatus, w_we_mie, w_we_mtvec, w_we_mscratch;
  logic        w_we_mepc, w_we_mcause;
  logic        w_trap_seq, w_pend_ext, w_pend_tim;

  assign w_mstatus = {24'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
  assign w_mie     = {20'd0, r_mie_meie, 3'd0, r_mie_mtie, 7'd0};
  assign w_mip     = {20'd0, r_mip_meip, 3'd0, r_mip_mtip, 7'd0};

  // Combinational read mux; unimplemented addresses read 0 and flag illegal
  always_comb begin
    w_rdata    = 32'd0;
    w_rd_valid = 1'b1;
    case (bus.i_csr_raddr)
      c_MSTATUS:   w_rdata = w_mstatus;
      c_MIE:       w_rdata = w_mie;
      c_MTVEC:     w_rdata = r_mtvec;
      c_MSCRATCH:  w_rdata = r_mscratch;
      c_MEPC:      w_rdata = r_mepc;
      c_MCAUSE:    w_rdata = r_mcause;
      c_MIP:       w_rdata = w_mip;
      c_MCYCLE:    w_rdata = r_mcycle[31:0];
      c_MCYCLEH:   w_rdata = r_mcycle[63:32];
      c_MINSTRET:  w_rdata = r_minstret[31:0];
      c_MINSTRETH: w_rdata = r_minstret[63:32];
      c_MHARTID:   w_rdata = 32'd0;
      default:     w_rd_valid = 1'b0;
    endcase
  end

  // Writable address decode (mip and mhartid are read-only)
  always_comb begin
    case (bus.i_csr_waddr)
      c_MSTATUS, c_MIE, c_MTVEC, c_MSCRATCH, c_MEPC, c_MCAUSE,
      c_MCYCLE, c_MCYCLEH, c_MINSTRET, c_MINSTRETH: w_wr_valid = 1'b1;
      default:                                      w_wr_valid = 1'b0;
    endcase
  end

  assign bus.o_csr_rdata   = w_rdata;
  assign bus.o_csr_illegal = ~w_rd_valid | (bus.i_csr_wen & ~w_wr_valid);

  // Trap/mret own mstatus, mepc and mcause for the cycle they occur
  assign w_trap_seq    = i_trap | i_mret;
  assign w_we_mstatus  = bus.i_csr_wen && bus.i_csr_waddr == c_MSTATUS && !w_trap_seq;
  assign w_we_mepc     = bus.i_csr_wen && bus.i_csr_waddr == c_MEPC    && !w_trap_seq;
  assign w_we_mcause   = bus.i_csr_wen && bus.i_csr_waddr == c_MCAUSE  && !w_trap_seq;
  assign w_we_mie      = bus.i_csr_wen && bus.i_csr_waddr == c_MIE;
  assign w_we_mtvec    = bus.i_csr_wen && bus.i_csr_waddr == c_MTVEC;
  assign w_we_mscratch = bus.i_csr_wen && bus.i_csr_waddr == c_MSCRATCH;

  assign w_mcycle_inc   = r_mcycle + 64'd1;
  assign w_minstret_inc = i_retire ? r_minstret + 64'd1 : r_minstret;

  // Counter next state: a written half replaces the increment, the other half keeps its carry
  always_comb begin
    w_mcycle_nxt   = w_mcycle_inc;
    w_minstret_nxt = w_minstret_inc;
    if (bus.i_csr_wen) begin
      if (bus.i_csr_waddr == c_MCYCLE)    w_mcycle_nxt[31:0]    = bus.i_csr_wdata;
      if (bus.i_csr_waddr == c_MCYCLEH)   w_mcycle_nxt[63:32]   = bus.i_csr_wdata;
      if (bus.i_csr_waddr == c_MINSTRET)  w_minstret_nxt[31:0]  = bus.i_csr_wdata;
      if (bus.i_csr_waddr == c_MINSTRETH) w_minstret_nxt[63:32] = bus.i_csr_wdata;
    end
  end

  // Counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else begin
      r_mcycle   <= w_mcycle_nxt;
      r_minstret <= w_minstret_nxt;
    end
  end

  // Single-flop capture of the asynchronous interrupt lines into mip
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mip_meip <= 1'b0;
      r_mip_mtip <= 1'b0;
    end else begin
      r_mip_meip <= i_irq_ext;
      r_mip_mtip <= i_irq_timer;
    end
  end

  // Control CSRs: trap beats mret, and both beat software writes to mstatus/mepc/mcause
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie_meie     <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mtvec        <= MTVEC_RST;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
    end else begin
      if (i_trap) begin
        r_mepc         <= i_trap_epc & ~32'd3;
        r_mcause       <= i_trap_cause;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (i_mret) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end
      if (w_we_mstatus) begin
        r_mstatus_mie  <= bus.i_csr_wdata[3];
        r_mstatus_mpie <= bus.i_csr_wdata[7];
      end
      if (w_we_mepc)     r_mepc     <= bus.i_csr_wdata & ~32'd3;
      if (w_we_mcause)   r_mcause   <= bus.i_csr_wdata;
      if (w_we_mtvec)    r_mtvec    <= bus.i_csr_wdata & ~32'd3;
      if (w_we_mscratch) r_mscratch <= bus.i_csr_wdata;
      if (w_we_mie) begin
        r_mie_meie <= bus.i_csr_wdata[11];
        r_mie_mtie <= bus.i_csr_wdata[7];
      end
    end
  end

  assign w_pend_ext    = r_mie_meie & r_mip_meip;
  assign w_pend_tim    = r_mie_mtie & r_mip_mtip;
  assign o_irq_pending = r_mstatus_mie & (w_pend_ext | w_pend_tim);
  assign o_irq_cause   = w_pend_ext ? c_CAUSE_EXT : c_CAUSE_TIM;
  assign o_mtvec       = r_mtvec;
  assign o_mepc        = r_mepc;

endmodule
`default_nettype wire

// File: tb/tb_core_csr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_core_csr : directed self-checking bench for core_csr.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_core_csr;
  logic        clk = 1'b0;
  logic        rst;
  logic        retire, trap, mret, irq_ext, irq_timer;
  logic [31:0] trap_cause, trap_epc;
  logic        irq_pending;
  logic [31:0] irq_cause, mtvec, mepc;
  int          vectors = 0;
  int          miscompares = 0;

  core_csr_if bus();

  core_csr #(.XLEN(32), .MTVEC_RST(32'h0000_0100)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .i_retire(retire), .i_trap(trap), .i_trap_cause(trap_cause),
    .i_trap_epc(trap_epc), .i_mret(mret),
    .i_irq_ext(irq_ext), .i_irq_timer(irq_timer),
    .o_irq_pending(irq_pending), .o_irq_cause(irq_cause),
    .o_mtvec(mtvec), .o_mepc(mepc)
  );

  always #5 clk = ~clk;

  // Drives one CSR write for a single rising edge; returns at the following falling edge
  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.i_csr_wen = 1'b1; bus.i_csr_waddr = a; bus.i_csr_wdata = d;
    @(negedge clk);
    bus.i_csr_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_csr_raddr = 12'h300; bus.i_csr_wen = 1'b0;
    bus.i_csr_waddr = 12'h0;   bus.i_csr_wdata = 32'h0;
    retire = 0; trap = 0; mret = 0; irq_ext = 0; irq_timer = 0;
    trap_cause = 0; trap_epc = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if (mtvec !== 32'h0000_0100) begin miscompares++; $display("FAIL rst_mtvec: got %h want %h", mtvec, 32'h100); end
    vectors++;
    if (mepc !== 32'h0 || irq_pending !== 1'b0) begin miscompares++; $display("FAIL rst_mepc_pend: got %h/%b want 0/0", mepc, irq_pending); end
    vectors++;
    if (irq_cause !== 32'h8000_0007) begin miscompares++; $display("FAIL rst_cause: got %h want 80000007", irq_cause); end
    bus.i_csr_raddr = 12'hB00; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_mcycle: got %h want 0", bus.o_csr_rdata); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_write_read();
    // Same-cycle read returns the old value
    @(negedge clk);
    bus.i_csr_wen = 1'b1; bus.i_csr_waddr = 12'h340; bus.i_csr_wdata = 32'hA5A5_0001;
    bus.i_csr_raddr = 12'h340; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h0) begin miscompares++; $display("FAIL mscratch_old: got %h want 0", bus.o_csr_rdata); end
    @(negedge clk); bus.i_csr_wen = 1'b0; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'hA5A5_0001) begin miscompares++; $display("FAIL mscratch_new: got %h want a5a50001", bus.o_csr_rdata); end
    csr_write(12'h341, 32'h8000_0007);
    bus.i_csr_raddr = 12'h341; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h8000_0004 || mepc !== 32'h8000_0004) begin miscompares++; $display("FAIL mepc_align: got %h/%h want 80000004", bus.o_csr_rdata, mepc); end
    csr_write(12'h305, 32'h0000_0203);
    vectors++;
    if (mtvec !== 32'h0000_0200) begin miscompares++; $display("FAIL mtvec_align: got %h want 00000200", mtvec); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    bus.i_csr_raddr = 12'h7C0; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h0 || bus.o_csr_illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_read: got %h/%b want 0/1", bus.o_csr_rdata, bus.o_csr_illegal); end
    bus.i_csr_raddr = 12'h300; #1;
    vectors++;
    if (bus.o_csr_illegal !== 1'b0) begin miscompares++; $display("FAIL legal_read: got %b want 0", bus.o_csr_illegal); end
    bus.i_csr_wen = 1'b1; bus.i_csr_waddr = 12'h344; bus.i_csr_wdata = 32'hFFFF_FFFF; #1;
    vectors++;
    if (bus.o_csr_illegal !== 1'b1) begin miscompares++; $display("FAIL ro_write_flag: got %b want 1", bus.o_csr_illegal); end
    @(negedge clk); bus.i_csr_wen = 1'b0;
    bus.i_csr_raddr = 12'h344; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h0) begin miscompares++; $display("FAIL ro_write_ignored: got %h want 0", bus.o_csr_rdata); end
  endtask

  task automatic test_mcycle_carry();
    csr_write(12'hB80, 32'h0);
    csr_write(12'hB00, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.i_csr_raddr = 12'hB00; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h0) begin miscompares++; $display("FAIL mcycle_lo_wrap: got %h want 0", bus.o_csr_rdata); end
    bus.i_csr_raddr = 12'hB80; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h1) begin miscompares++; $display("FAIL mcycle_hi_carry: got %h want 1", bus.o_csr_rdata); end
  endtask

  task automatic test_irq();
    csr_write(12'h300, 32'h8);
    csr_write(12'h304, 32'h800);
    irq_ext = 1'b1; #1;
    vectors++;
    if (irq_pending !== 1'b0) begin miscompares++; $display("FAIL irq_latency: got %b want 0", irq_pending); end
    @(negedge clk);
    vectors++;
    if (irq_pending !== 1'b1 || irq_cause !== 32'h8000_000B) begin miscompares++; $display("FAIL irq_ext: got %b/%h want 1/8000000b", irq_pending, irq_cause); end
    irq_timer = 1'b1;
    csr_write(12'h304, 32'h880);
    vectors++;
    if (irq_pending !== 1'b1 || irq_cause !== 32'h8000_000B) begin miscompares++; $display("FAIL irq_prio: got %b/%h want 1/8000000b", irq_pending, irq_cause); end
    irq_ext = 1'b0;
    @(negedge clk);
    vectors++;
    if (irq_pending !== 1'b1 || irq_cause !== 32'h8000_0007) begin miscompares++; $display("FAIL irq_timer: got %b/%h want 1/80000007", irq_pending, irq_cause); end
    irq_timer = 1'b0;
    csr_write(12'h300, 32'h0);
    vectors++;
    if (irq_pending !== 1'b0) begin miscompares++; $display("FAIL irq_masked: got %b want 0", irq_pending); end
  endtask

  task automatic test_trap_mret();
    csr_write(12'h300, 32'h8);
    trap = 1'b1; trap_cause = 32'd2; trap_epc = 32'h100;
    @(negedge clk); trap = 1'b0;
    bus.i_csr_raddr = 12'h300; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h80) begin miscompares++; $display("FAIL trap_mstatus: got %h want 80", bus.o_csr_rdata); end
    bus.i_csr_raddr = 12'h341; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h100) begin miscompares++; $display("FAIL trap_mepc: got %h want 100", bus.o_csr_rdata); end
    bus.i_csr_raddr = 12'h342; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h2) begin miscompares++; $display("FAIL trap_mcause: got %h want 2", bus.o_csr_rdata); end
    @(negedge clk); mret = 1'b1;
    @(negedge clk); mret = 1'b0;
    bus.i_csr_raddr = 12'h300; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h88) begin miscompares++; $display("FAIL mret_mstatus: got %h want 88", bus.o_csr_rdata); end
  endtask

  task automatic test_priority();
    // trap + mret + mepc write together: trap wins everywhere
    @(negedge clk);
    trap = 1'b1; mret = 1'b1; trap_cause = 32'd5; trap_epc = 32'h207;
    bus.i_csr_wen = 1'b1; bus.i_csr_waddr = 12'h341; bus.i_csr_wdata = 32'h55;
    @(negedge clk);
    mret = 1'b0; bus.i_csr_waddr = 12'h340; bus.i_csr_wdata = 32'h77;
    trap_cause = 32'd6; trap_epc = 32'h300;
    bus.i_csr_raddr = 12'h341; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h204) begin miscompares++; $display("FAIL trap_over_write: got %h want 204", bus.o_csr_rdata); end
    bus.i_csr_raddr = 12'h300; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h80) begin miscompares++; $display("FAIL trap_over_mret: got %h want 80", bus.o_csr_rdata); end
    // trap with an mscratch write: the write still lands
    @(negedge clk);
    trap = 1'b0; bus.i_csr_wen = 1'b0;
    bus.i_csr_raddr = 12'h340; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h77) begin miscompares++; $display("FAIL trap_other_write: got %h want 77", bus.o_csr_rdata); end
    bus.i_csr_raddr = 12'h342; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h6) begin miscompares++; $display("FAIL trap2_mcause: got %h want 6", bus.o_csr_rdata); end
    // write to minstret wins over the same-cycle retire
    @(negedge clk);
    retire = 1'b1;
    bus.i_csr_wen = 1'b1; bus.i_csr_waddr = 12'hB02; bus.i_csr_wdata = 32'h1234;
    @(negedge clk);
    retire = 1'b0; bus.i_csr_wen = 1'b0;
    bus.i_csr_raddr = 12'hB02; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h1234) begin miscompares++; $display("FAIL minstret_write_wins: got %h want 1234", bus.o_csr_rdata); end
    @(negedge clk); retire = 1'b1;
    @(negedge clk); retire = 1'b0; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h1235) begin miscompares++; $display("FAIL minstret_inc: got %h want 1235", bus.o_csr_rdata); end
  endtask

  task automatic test_async_reset();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    bus.i_csr_raddr = 12'hB00; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h0) begin miscompares++; $display("FAIL async_mcycle: got %h want 0", bus.o_csr_rdata); end
    bus.i_csr_raddr = 12'hB02; #1;
    vectors++;
    if (bus.o_csr_rdata !== 32'h0) begin miscompares++; $display("FAIL async_minstret: got %h want 0", bus.o_csr_rdata); end
    vectors++;
    if (mtvec !== 32'h100 || mepc !== 32'h0) begin miscompares++; $display("FAIL async_vec: got %h/%h want 100/0", mtvec, mepc); end
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_illegal();
    test_mcycle_carry();
    test_irq();
    test_trap_mret();
    test_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/core_csr.md
CORE_CSR -- requirements
Module: core_csr

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter MTVEC_RST, default 32'h0000_0000, reset value of mtvec.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_csr_raddr  input  12  CSR read address.
REQ-006 SHALL have port o_csr_rdata  output  32  read data, combinational from i_csr_raddr.
REQ-007 SHALL have port o_csr_illegal  output  1  i_csr_raddr is unimplemented, or i_csr_wen targets a read-only or unimplemented CSR.
REQ-008 SHALL have ports i_csr_wen / i_csr_waddr / i_csr_wdata  input  1/12/32  CSR write strobe, address, data.
REQ-009 SHALL have port i_retire  input  1  one instruction retired this cycle.
REQ-010 SHALL have ports i_trap / i_trap_cause / i_trap_epc  input  1/32/32  trap entry strobe, cause, faulting PC.
REQ-011 SHALL have port i_mret  input  1  mret executed.
REQ-012 SHALL have ports i_irq_ext / i_irq_timer  input  1/1  level interrupt lines, asynchronous to the pipeline.
REQ-013 SHALL have ports o_irq_pending / o_irq_cause  output  1/32  interrupt to take, with its mcause value.
REQ-014 SHALL have ports o_mtvec / o_mepc  output  32/32  current register values for fetch redirect.

Function
REQ-015 SHALL implement these CSRs: mstatus 0x300 (bits MIE[3], MPIE[7] only; all other bits read 0), mie 0x304 (bits MTIE[7], MEIE[11] only), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, mhartid 0xF14 (read-only, reads 0).
REQ-016 SHALL return 0 on o_csr_rdata and assert o_csr_illegal for any unimplemented read address.
REQ-017 SHALL apply a write on the clock edge after i_csr_wen; a read of the same address in the same cycle SHALL return the old value.
REQ-018 SHALL ignore writes to read-only or unimplemented addresses; o_csr_illegal SHALL be asserted in that cycle.
REQ-019 SHALL force mtvec[1:0] and mepc[1:0] to 0 on every write (direct mode only).
REQ-020 SHALL treat mcycle as one 64-bit counter incremented every cycle, carrying from the low word into mcycleh and wrapping from all-ones to 0.
REQ-021 SHALL treat minstret as one 64-bit counter incremented on cycles with i_retire=1, with the same carry and wrap rules as mcycle.
REQ-022 SHALL make a software write to a counter half take priority over that cycle's increment; the other half SHALL still receive any carry.
REQ-023 SHALL register i_irq_ext and i_irq_timer once into mip.MEIP[11] and mip.MTIP[7], giving a 1-cycle latency.
REQ-024 SHALL drive o_irq_pending = mstatus.MIE & |(mie & mip).
REQ-025 SHALL drive o_irq_cause = 32'h8000_000B when external is pending, else 32'h8000_0007 (external has priority over timer).
REQ-026 On i_trap, SHALL update: mepc <= {i_trap_epc[31:2],2'b00}; mcause <= i_trap_cause; MPIE <= MIE; MIE <= 0.
REQ-027 On i_mret, SHALL update: MIE <= MPIE; MPIE <= 1.
REQ-028 SHALL give i_trap priority over i_mret when both are asserted in one cycle.
REQ-029 SHALL give i_trap or i_mret priority over a same-cycle CSR write to mstatus, mepc or mcause; writes to all other CSRs in that cycle SHALL still apply.

Reset
REQ-030 While i_rst=1, SHALL hold: mtvec=MTVEC_RST; all other CSRs 0; mip sync flops 0.
REQ-031 While i_rst=1, SHALL hold: o_irq_pending=0; o_irq_cause=32'h8000_0007; o_mepc=0.
REQ-032 A reset asserted mid-operation SHALL clear all state immediately without waiting for a clock edge.

Verification
REQ-033 Bench SHALL cover: write 0x341 with 0x8000_0007, read next cycle -> 0x8000_0004.
REQ-034 Bench SHALL cover: preload mcycle=0xFFFF_FFFF and mcycleh=0; one clock -> mcycle=0 and mcycleh=1.
REQ-035 Bench SHALL cover: mstatus=0x8 and mie=0x800, raise i_irq_ext -> o_irq_pending=1 one cycle later and o_irq_cause=0x8000_000B; also raise i_irq_timer with mie=0x880 -> cause stays 0x8000_000B.
REQ-036 Bench SHALL cover: mstatus=0x8, pulse i_trap with cause 2 and epc 0x100 -> mstatus=0x80, mepc=0x100, mcause=2; then pulse i_mret -> mstatus=0x88.
REQ-037 Bench SHALL cover: i_trap together with a write of 0x55 to 0x341 -> mepc takes the trap value; write 0xB02 while i_retire=1 -> written value is kept.
REQ-038 Bench SHALL cover: read 0x7C0 -> rdata 0 and o_csr_illegal=1; assert i_rst asynchronously mid-count -> counters read 0 before the next clock edge.
